onehot_encoder_pipe: RTL and testbench

- Parametrised, registered successor to the fixed 8-to-3 one-hot encoder.
- Encodes an N-bit request vector to a binary index.
- Modes: strict one-hot, LSB-priority, MSB-priority.
- Adds a valid/ready handshake, an invalid-input flag and a saturating error counter; used wherever request/select vectors are converted to indices between pipeline stages.

---
 rtl/onehot_enc_pkg.sv | 13 +
 rtl/onehot_enc_core.sv | 61 ++++++
 rtl/onehot_encoder_pipe.sv | 80 ++++++++
 tb/tb_onehot_encoder_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_enc_pkg.sv
// rtl/onehot_enc_pkg.sv - shared mode encodings and code-width helper for the one-hot encoder
package onehot_enc_pkg;

   localparam logic [1:0] MODE_STRICT = 2'b00;
   localparam logic [1:0] MODE_LSB    = 2'b01;
   localparam logic [1:0] MODE_MSB    = 2'b10;

   // Narrowest vectors still need a one-bit code.
   function automatic int calc_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/onehot_enc_core.sv
// rtl/onehot_enc_core.sv - combinational N-bit request vector to binary index encoder
module onehot_enc_core
   import onehot_enc_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = calc_w(N)
) (
   input  logic [N-1:0] data,
   input  logic [1:0]   mode,
   output logic [W-1:0] code,
   output logic         err
);

   logic         any_set;
   logic         multi_set;
   logic [W-1:0] lsb_idx;
   logic [W-1:0] msb_idx;

   // One ascending scan yields lowest index, highest index and a more-than-one flag.
   always_comb begin
      any_set   = 1'b0;
      multi_set = 1'b0;
      lsb_idx   = '0;
      msb_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (data[i]) begin
            if (!any_set) lsb_idx = W'(i);
            if (any_set) multi_set = 1'b1;
            any_set = 1'b1;
            msb_idx = W'(i);
         end
      end
   end

   always_comb begin
      code = '0;
      err  = 1'b1;
      case (mode)
         MODE_LSB: begin
            if (any_set) begin
               code = lsb_idx;
               err  = 1'b0;
            end
         end
         MODE_MSB: begin
            if (any_set) begin
               code = msb_idx;
               err  = 1'b0;
            end
         end
         default: begin
            // Strict: with exactly one bit set the lowest index is that bit.
            if (any_set && !multi_set) begin
               code = lsb_idx;
               err  = 1'b0;
            end
         end
      endcase
   end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// rtl/onehot_encoder_pipe.sv - registered one-hot encoder with valid/ready handshake and error counter
module onehot_encoder_pipe
   import onehot_enc_pkg::*;
#(
   parameter  int N         = 8,
   parameter  int ERR_CNT_W = 8,
   localparam int W         = calc_w(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_code,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 err_clr
);

   logic                 out_valid_q, out_valid_d;
   logic [W-1:0]         out_code_q,  out_code_d;
   logic                 out_err_q,   out_err_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic [ERR_CNT_W-1:0] err_base;
   logic [W-1:0]         core_code;
   logic                 core_err;
   logic                 accept;

   onehot_enc_core #(.N(N)) u_core (
      .data (in_data),
      .mode (mode),
      .code (core_code),
      .err  (core_err)
   );

   always_comb begin
      in_ready    = !out_valid_q || out_ready;
      accept      = in_valid && in_ready;
      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_err_d   = out_err_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_code_d  = core_code;
         out_err_d   = core_err;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // Clear takes effect before the increment of a same-cycle erroneous accept.
      err_base    = err_clr ? '0 : err_count_q;
      err_count_d = err_base;
      if (accept && core_err && !(&err_base)) begin
         err_count_d = err_base + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_err_q   <= out_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_err   = out_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb/tb_onehot_encoder_pipe.sv - self-checking bench for onehot_encoder_pipe (N=8 and N=5 instances)
module tb_onehot_encoder_pipe;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic       in_valid, out_ready, err_clr;
   logic [7:0] in_data;
   logic [1:0] mode;

   logic       in_ready_a, out_valid_a, out_err_a;
   logic [2:0] out_code_a;
   logic [7:0] err_count_a;
   logic       in_ready_b, out_valid_b, out_err_b;
   logic [2:0] out_code_b;
   logic [1:0] err_count_b;

   logic       in_valid5, out_ready5, err_clr5;
   logic [4:0] in_data5;
   logic [1:0] mode5;
   logic       in_ready5, out_valid5, out_err5;
   logic [2:0] out_code5;
   logic [7:0] err_count5;

   onehot_encoder_pipe #(.N(8), .ERR_CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .mode(mode), .out_valid(out_valid_a), .out_ready(out_ready), .out_code(out_code_a),
      .out_err(out_err_a), .err_count(err_count_a), .err_clr(err_clr)
   );

   onehot_encoder_pipe #(.N(8), .ERR_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .mode(mode), .out_valid(out_valid_b), .out_ready(out_ready), .out_code(out_code_b),
      .out_err(out_err_b), .err_count(err_count_b), .err_clr(err_clr)
   );

   onehot_encoder_pipe #(.N(5), .ERR_CNT_W(8)) dut_5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .mode(mode5), .out_valid(out_valid5), .out_ready(out_ready5), .out_code(out_code5),
      .out_err(out_err5), .err_count(err_count5), .err_clr(err_clr5)
   );

   int n_checks;
   int n_fail;

   // Reference model state for the two N=8 instances (identical except counter width).
   bit         m_valid;
   logic [2:0] m_code;
   bit         m_err;
   int         m_cnt_a, m_cnt_b, m_cnt5;
   bit         exp_in_ready;
   logic       obs_ready_a, obs_ready_b;

   // Encoding from the rules: lowest set bit via x & -x, highest via floor(log2(x)).
   function automatic void ref_enc(input int x, input logic [1:0] md, output int code, output bit err);
      code = 0;
      err  = 1'b1;
      if (x == 0) return;
      if (md == 2'b01) begin
         code = $clog2(x & -x);
         err  = 1'b0;
      end else if (md == 2'b10) begin
         code = $clog2(x + 1) - 1;
         err  = 1'b0;
      end else if ($countones(x) == 1) begin
         code = $clog2(x);
         err  = 1'b0;
      end
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_code  = '0;
      m_err   = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      m_cnt5  = 0;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_valid5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One clock of stimulus on the N=8 pair; updates the model, leaves checking to the caller.
   task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] md, input bit ordy, input bit clr);
      int c;
      bit e;
      bit acc;
      in_valid  = v;
      in_data   = d;
      mode      = md;
      out_ready = ordy;
      err_clr   = clr;
      #1;
      obs_ready_a  = in_ready_a;
      obs_ready_b  = in_ready_b;
      exp_in_ready = !m_valid || ordy;
      acc          = v && exp_in_ready;
      ref_enc(int'(d), md, c, e);
      @(posedge clk);
      if (acc) begin
         m_valid = 1'b1;
         m_code  = 3'(c);
         m_err   = e;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      if (clr) begin
         m_cnt_a = 0;
         m_cnt_b = 0;
      end
      if (acc && e) begin
         if (m_cnt_a < 255) m_cnt_a++;
         if (m_cnt_b < 3) m_cnt_b++;
      end
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_a); end
      n_checks++; if (out_code_a !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", out_code_a); end
      n_checks++; if (out_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err_a); end
      n_checks++; if (err_count_a !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", err_count_a); end
      n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
      n_checks++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1) begin
         n_fail++; $display("FAIL reset_n5: got valid=%b ready=%b want 0/1", out_valid5, in_ready5); end
   endtask

   task automatic test_strict_onehot();
      drive(1'b1, 8'h10, 2'b00, 1'b1, 1'b0);
      n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL strict_valid: got %b want 1", out_valid_a); end
      n_checks++; if (out_code_a !== 3'd4) begin n_fail++; $display("FAIL strict_code: got %0d want 4", out_code_a); end
      n_checks++; if (out_err_a !== 1'b0) begin n_fail++; $display("FAIL strict_err: got %b want 0", out_err_a); end
      n_checks++; if (err_count_a !== 8'd0) begin n_fail++; $display("FAIL strict_cnt: got %0d want 0", err_count_a); end
      drive(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
      n_checks++; if (out_valid_a !== 1'b0 || out_code_a !== 3'd4) begin
         n_fail++; $display("FAIL drain_hold: got valid=%b code=%0d want 0/4", out_valid_a, out_code_a); end
   endtask

   task automatic test_modes();
      logic [1:0] md_tab [4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [2:0] code_tab [4] = '{3'd0, 3'd2, 3'd3, 3'd0};
      bit         err_tab [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 8'h0C, md_tab[k], 1'b1, 1'b0);
         n_checks++; if (out_valid_a !== 1'b1 || out_code_a !== code_tab[k] || out_err_a !== err_tab[k]) begin
            n_fail++; $display("FAIL mode%0d_0C: got v=%b code=%0d err=%b want 1/%0d/%b",
                               k, out_valid_a, out_code_a, out_err_a, code_tab[k], err_tab[k]); end
         if (k == 0) begin
            n_checks++; if (err_count_a !== 8'd1) begin n_fail++; $display("FAIL strict_multi_cnt: got %0d want 1", err_count_a); end
         end
      end
      n_checks++; if (err_count_a !== 8'd2) begin n_fail++; $display("FAIL modes_cnt: got %0d want 2", err_count_a); end
   endtask

   task automatic test_backpressure();
      logic [7:0] pending [$];
      logic [2:0] got [$];
      logic [2:0] want [3] = '{3'd0, 3'd1, 3'd7};
      int cycles;
      drive(1'b1, 8'h01, 2'b00, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'h02, 2'b00, 1'b0, 1'b0);
         n_checks++; if (obs_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_code_a !== 3'd0) begin
            n_fail++; $display("FAIL bp_hold: got ready=%b valid=%b code=%0d want 0/1/0", obs_ready_a, out_valid_a, out_code_a); end
      end
      pending = '{8'h02, 8'h80};
      cycles  = 0;
      while ((pending.size() != 0 || out_valid_a) && cycles < 20) begin
         if (out_valid_a) got.push_back(out_code_a);
         if (pending.size() != 0) drive(1'b1, pending[0], 2'b00, 1'b1, 1'b0);
         else drive(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
         if (exp_in_ready && pending.size() != 0) void'(pending.pop_front());
         cycles++;
      end
      n_checks++; if (cycles >= 20) begin n_fail++; $display("FAIL bp_timeout: got %0d cycles want <20", cycles); end
      n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d results want 3", got.size()); end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         n_checks++; if (got[k] !== want[k]) begin n_fail++; $display("FAIL bp_order%0d: got %0d want %0d", k, got[k], want[k]); end
      end
   endtask

   task automatic test_saturation();
      drive(1'b0, 8'h00, 2'b00, 1'b1, 1'b1);
      n_checks++; if (err_count_a !== 8'd0 || err_count_b !== 2'd0) begin
         n_fail++; $display("FAIL clr_only: got a=%0d b=%0d want 0/0", err_count_a, err_count_b); end
      drive(1'b1, 8'h00, 2'b01, 1'b1, 1'b0);
      n_checks++; if (out_code_a !== 3'd0 || out_err_a !== 1'b1) begin
         n_fail++; $display("FAIL zero_lsb: got code=%0d err=%b want 0/1", out_code_a, out_err_a); end
      drive(1'b1, 8'h00, 2'b10, 1'b1, 1'b0);
      n_checks++; if (out_code_a !== 3'd0 || out_err_a !== 1'b1) begin
         n_fail++; $display("FAIL zero_msb: got code=%0d err=%b want 0/1", out_code_a, out_err_a); end
      repeat (5) drive(1'b1, 8'hFF, 2'b00, 1'b1, 1'b0);
      n_checks++; if (err_count_b !== 2'd3) begin n_fail++; $display("FAIL sat_b: got %0d want 3", err_count_b); end
      n_checks++; if (err_count_a !== 8'd7) begin n_fail++; $display("FAIL cnt_a7: got %0d want 7", err_count_a); end
      drive(1'b1, 8'h00, 2'b00, 1'b1, 1'b1);
      n_checks++; if (err_count_a !== 8'd1 || err_count_b !== 2'd1) begin
         n_fail++; $display("FAIL clr_and_err: got a=%0d b=%0d want 1/1", err_count_a, err_count_b); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      int r;
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 3);
         if (r == 0) d = 8'h00;
         else if (r == 1) d = 8'(1 << $urandom_range(0, 7));
         else d = 8'($urandom);
         drive(1'($urandom), d, 2'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         n_checks++; if (obs_ready_a !== exp_in_ready || obs_ready_b !== exp_in_ready) begin
            n_fail++; $display("FAIL rnd_ready@%0d: got %b/%b want %b", k, obs_ready_a, obs_ready_b, exp_in_ready); end
         n_checks++; if (out_valid_a !== m_valid || out_code_a !== m_code || out_err_a !== m_err) begin
            n_fail++; $display("FAIL rnd_out@%0d: got v=%b c=%0d e=%b want %b/%0d/%b",
                               k, out_valid_a, out_code_a, out_err_a, m_valid, m_code, m_err); end
         n_checks++; if (err_count_a !== 8'(m_cnt_a) || err_count_b !== 2'(m_cnt_b)) begin
            n_fail++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", k, err_count_a, err_count_b, m_cnt_a, m_cnt_b); end
      end
   endtask

   task automatic test_non_pow2();
      int c;
      bit e;
      in_valid5  = 1'b1;
      out_ready5 = 1'b1;
      err_clr5   = 1'b0;
      in_data5   = 5'b10110;
      mode5      = 2'b10;
      @(posedge clk); #1;
      n_checks++; if (out_valid5 !== 1'b1 || out_code5 !== 3'd4 || out_err5 !== 1'b0) begin
         n_fail++; $display("FAIL n5_msb: got v=%b code=%0d err=%b want 1/4/0", out_valid5, out_code5, out_err5); end
      for (int md = 0; md < 4; md++) begin
         for (int x = 0; x < 32; x++) begin
            in_data5 = 5'(x);
            mode5    = 2'(md);
            ref_enc(x, 2'(md), c, e);
            if (e && m_cnt5 < 255) m_cnt5++;
            @(posedge clk); #1;
            n_checks++; if (out_code5 !== 3'(c) || out_err5 !== e || out_code5 > 3'd4) begin
               n_fail++; $display("FAIL n5_sweep m%0d x%0d: got code=%0d err=%b want %0d/%b", md, x, out_code5, out_err5, c, e); end
         end
      end
      n_checks++; if (err_count5 !== 8'(m_cnt5)) begin n_fail++; $display("FAIL n5_cnt: got %0d want %0d", err_count5, m_cnt5); end
      in_valid5 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_transfer();
      drive(1'b1, 8'h40, 2'b00, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
      n_checks++; if (out_valid_a !== 1'b1 || obs_ready_a !== 1'b0) begin
         n_fail++; $display("FAIL pre_rst_hold: got valid=%b ready=%b want 1/0", out_valid_a, obs_ready_a); end
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h20;
      @(posedge clk); #1;
      n_checks++; if (out_valid_a !== 1'b0 || out_code_a !== 3'd0 || out_err_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_out: got v=%b c=%0d e=%b want 0/0/0", out_valid_a, out_code_a, out_err_a); end
      n_checks++; if (err_count_a !== 8'd0 || err_count_b !== 2'd0) begin
         n_fail++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", err_count_a, err_count_b); end
      rst      = 1'b0;
      in_valid = 1'b0;
      model_reset();
      #1;
      n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", in_ready_a); end
      drive(1'b1, 8'h08, 2'b00, 1'b1, 1'b0);
      n_checks++; if (out_valid_a !== 1'b1 || out_code_a !== 3'd3 || out_err_a !== 1'b0) begin
         n_fail++; $display("FAIL post_rst_enc: got v=%b c=%0d e=%b want 1/3/0", out_valid_a, out_code_a, out_err_a); end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      mode       = 2'b00;
      out_ready  = 1'b1;
      err_clr    = 1'b0;
      in_valid5  = 1'b0;
      in_data5   = 5'd0;
      mode5      = 2'b00;
      out_ready5 = 1'b1;
      err_clr5   = 1'b0;
      model_reset();
      test_reset();
      test_strict_onehot();
      test_modes();
      test_backpressure();
      test_saturation();
      test_random();
      test_non_pow2();
      test_reset_mid_transfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
